dat_block_sequencer: RTL and testbench

//  Host-side scheduler for the DAT block: accepts one transfer request (dir, N blocks, size, timeout).

---
 rtl/dat_seq_pkg.sv | 25 ++
 rtl/dat_block_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_dat_block_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dat_seq_pkg.sv
// -----------------------------------------------------------------------------
// dat_seq_pkg
// Shared definitions for the DAT block sequencer: FSM state encoding and
// default widths for the block counter and the DAT timeout value.
// Optional build macro: DAT_SEQ_RETRY_EN (adds the per-block retry default).
// -----------------------------------------------------------------------------
package dat_seq_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int TO_W_DEFAULT  = 16;
`ifdef DAT_SEQ_RETRY_EN
  localparam int MAX_RETRY_DEFAULT = 2;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STALL = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5,
    FAIL  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/dat_block_sequencer.sv
// -----------------------------------------------------------------------------
// dat_block_sequencer
// Host-side scheduler for the DAT block. Accepts one transfer request, issues
// one newService pulse per block, waits for DAT to complete (or time out),
// counts finished blocks and reports done/error. Block issue is held off while
// DAT is busy or the data FIFO cannot service the block.
//
// Optional build macro: DAT_SEQ_RETRY_EN
//   defined     : a DAT timeout re-issues the same block up to MAX_RETRY times
//   not defined : the first DAT timeout ends the transfer with error
//
// Ports
//   clock, reset          clock; asynchronous active-low reset
//   req_*                 request handshake and transfer configuration
//   abort                 cancels a running transfer (ignored when idle)
//   fifo_full/fifo_empty  read-side / write-side FIFO back-pressure
//   dat_* (out)           control towards DAT: start pulse, latched config,
//                         multiblock flag, reset pulse
//   dat_* (in)            DAT status: complete, timeOutFail, IDLE
//   busy, done, error     transfer status; done/error are one-cycle pulses
//   blocks_done           blocks completed in the current/last transfer
// -----------------------------------------------------------------------------
module dat_block_sequencer
  import dat_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int TO_W  = TO_W_DEFAULT
`ifdef DAT_SEQ_RETRY_EN
  , parameter int MAX_RETRY = MAX_RETRY_DEFAULT
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [CNT_W-1:0] req_blocks,
  input  logic [3:0]       req_block_size,
  input  logic [TO_W-1:0]  req_timeout,
  input  logic             abort,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             dat_newService,
  output logic             dat_writeRead,
  output logic             dat_multiblock,
  output logic [3:0]       dat_blockSize,
  output logic [TO_W-1:0]  dat_timeout,
  output logic             dat_timeoutenable,
  output logic             dat_reset,
  input  logic             dat_complete,
  input  logic             dat_timeOutFail,
  input  logic             dat_IDLE,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] blocks_done
);

  seq_state_e       state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [CNT_W-1:0] blocks_done_reg, blocks_done_next;
  logic             write_reg, write_next;
  logic [3:0]       block_size_reg, block_size_next;
  logic [TO_W-1:0]  timeout_reg, timeout_next;
  logic             timeout_en_reg, timeout_en_next;
  logic             complete_prev_reg;
  logic             complete_rise;
  logic             fifo_stall;

`ifdef DAT_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;
  logic               retry_pulse_reg, retry_pulse_next;
`endif

  // DAT may hold complete as a level across cycles; only a fresh rise counts.
  assign complete_rise = dat_complete & ~complete_prev_reg;
  // Reads stall on a full read FIFO, writes stall on an empty write FIFO.
  assign fifo_stall    = write_reg ? fifo_empty : fifo_full;

  always_comb begin
    state_next       = state_reg;
    remaining_next   = remaining_reg;
    blocks_done_next = blocks_done_reg;
    write_next       = write_reg;
    block_size_next  = block_size_reg;
    timeout_next     = timeout_reg;
    timeout_en_next  = timeout_en_reg;
`ifdef DAT_SEQ_RETRY_EN
    retry_cnt_next   = retry_cnt_reg;
    retry_pulse_next = 1'b0;
`endif

    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          write_next       = req_write;
          block_size_next  = req_block_size;
          timeout_next     = req_timeout;
          timeout_en_next  = (req_timeout != '0);
          blocks_done_next = '0;
          remaining_next   = (req_blocks == '0) ? CNT_W'(1) : req_blocks;
`ifdef DAT_SEQ_RETRY_EN
          retry_cnt_next   = '0;
`endif
          state_next       = STALL;
        end
      end
      STALL: begin
        if (abort)                       state_next = FAIL;
        else if (dat_IDLE && !fifo_stall) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = abort ? FAIL : WAIT;
      end
      WAIT: begin
        // A completion beats a simultaneous timeout: the block did finish.
        if (abort)              state_next = FAIL;
        else if (complete_rise) state_next = NEXT;
        else if (dat_timeOutFail) begin
`ifdef DAT_SEQ_RETRY_EN
          if (retry_cnt_reg < RETRY_LIMIT) begin
            retry_cnt_next   = retry_cnt_reg + 1'b1;
            retry_pulse_next = 1'b1;
            state_next       = STALL;
          end else begin
            state_next = FAIL;
          end
`else
          state_next = FAIL;
`endif
        end
      end
      NEXT: begin
        if (abort) begin
          state_next = FAIL;
        end else begin
          blocks_done_next = (&blocks_done_reg) ? blocks_done_reg
                                                : blocks_done_reg + 1'b1;
          remaining_next   = remaining_reg - 1'b1;
`ifdef DAT_SEQ_RETRY_EN
          retry_cnt_next   = '0;
`endif
          state_next       = (remaining_reg == CNT_W'(1)) ? FIN : STALL;
        end
      end
      // FIN and FAIL are single-cycle exit states; the transfer has already
      // ended there, so abort has nothing left to cancel.
      FIN:     state_next = IDLE;
      FAIL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    req_ready      = (state_reg == IDLE);
    busy           = (state_reg != IDLE);
    dat_newService = (state_reg == ISSUE);
    done           = (state_reg == FIN);
    error          = (state_reg == FAIL);
    dat_multiblock = (state_reg != IDLE) && (remaining_reg > CNT_W'(1));
`ifdef DAT_SEQ_RETRY_EN
    dat_reset      = (state_reg == FAIL) | retry_pulse_reg;
`else
    dat_reset      = (state_reg == FAIL);
`endif
  end

  assign dat_writeRead     = write_reg;
  assign dat_blockSize     = block_size_reg;
  assign dat_timeout       = timeout_reg;
  assign dat_timeoutenable = timeout_en_reg;
  assign blocks_done       = blocks_done_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      remaining_reg     <= '0;
      blocks_done_reg   <= '0;
      write_reg         <= 1'b0;
      block_size_reg    <= '0;
      timeout_reg       <= '0;
      timeout_en_reg    <= 1'b0;
      complete_prev_reg <= 1'b0;
`ifdef DAT_SEQ_RETRY_EN
      retry_cnt_reg     <= '0;
      retry_pulse_reg   <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      remaining_reg     <= remaining_next;
      blocks_done_reg   <= blocks_done_next;
      write_reg         <= write_next;
      block_size_reg    <= block_size_next;
      timeout_reg       <= timeout_next;
      timeout_en_reg    <= timeout_en_next;
      complete_prev_reg <= dat_complete;
`ifdef DAT_SEQ_RETRY_EN
      retry_cnt_reg     <= retry_cnt_next;
      retry_pulse_reg   <= retry_pulse_next;
`endif
    end
  end

endmodule

// File: tb/tb_dat_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dat_block_sequencer
// Directed bench for dat_block_sequencer. Each request pushes its expected
// outcome (done/error, final blocks_done) to a scoreboard queue; a monitor pops
// and compares whenever the sequencer signals the end of a transfer.
// -----------------------------------------------------------------------------
module tb_dat_block_sequencer;

  localparam int CNT_W = 16;
  localparam int TO_W  = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [CNT_W-1:0] req_blocks = '0;
  logic [3:0]       req_block_size = '0;
  logic [TO_W-1:0]  req_timeout = '0;
  logic             abort = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_empty = 1'b0;
  logic             dat_newService;
  logic             dat_writeRead;
  logic             dat_multiblock;
  logic [3:0]       dat_blockSize;
  logic [TO_W-1:0]  dat_timeout;
  logic             dat_timeoutenable;
  logic             dat_reset;
  logic             dat_complete = 1'b0;
  logic             dat_timeOutFail = 1'b0;
  logic             dat_IDLE = 1'b1;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] blocks_done;

  dat_block_sequencer #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_blocks        (req_blocks),
    .req_block_size    (req_block_size),
    .req_timeout       (req_timeout),
    .abort             (abort),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .dat_newService    (dat_newService),
    .dat_writeRead     (dat_writeRead),
    .dat_multiblock    (dat_multiblock),
    .dat_blockSize     (dat_blockSize),
    .dat_timeout       (dat_timeout),
    .dat_timeoutenable (dat_timeoutenable),
    .dat_reset         (dat_reset),
    .dat_complete      (dat_complete),
    .dat_timeOutFail   (dat_timeOutFail),
    .dat_IDLE          (dat_IDLE),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .blocks_done       (blocks_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_err;
    int blocks;
  } exp_t;

  exp_t sb[$];
  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int ns_count      = 0;
  int end_count     = 0;
  int pushed        = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for the next newService pulse.
  task automatic wait_ns(input string tag);
    int n = 0;
    while (dat_newService !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ns_seen"}, {31'd0, dat_newService}, 32'd1);
  endtask

  // Called while newService is visible: DAT completes the block one cycle later.
  task automatic complete_block();
    tick();
    dat_complete = 1'b1;
    tick();
    dat_complete = 1'b0;
  endtask

  task automatic start_req(input bit wr, input int nblk, input int bsize, input int tmo,
                           input bit exp_err, input int exp_blocks);
    exp_t e;
    req_write      = wr;
    req_blocks     = CNT_W'(nblk);
    req_block_size = 4'(bsize);
    req_timeout    = TO_W'(tmo);
    req_valid      = 1'b1;
    e.is_err       = exp_err;
    e.blocks       = exp_blocks;
    sb.push_back(e);
    pushed++;
    $display("tb: request wr=%0d blocks=%0d size=%0d timeout=%0d", wr, nblk, bsize, tmo);
    tick();
    req_valid = 1'b0;
  endtask

  // Scoreboard monitor: one line per finished transfer.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset === 1'b1) begin
      if (dat_newService === 1'b1) ns_count++;
      if (done === 1'b1 || error === 1'b1) begin
        end_count++;
        check("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("tb: transfer end done=%0d error=%0d blocks_done=%0d (expected error=%0d blocks=%0d)",
                   done, error, blocks_done, e.is_err, e.blocks);
          check("end_done",        {31'd0, done},      {31'd0, !e.is_err});
          check("end_error",       {31'd0, error},     {31'd0, e.is_err});
          check("end_dat_reset",   {31'd0, dat_reset}, {31'd0, e.is_err});
          check("end_blocks_done", {16'd0, blocks_done}, e.blocks);
        end
      end
    end
  end

  initial begin
    int ns_before;
    int ns_seen;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_req_ready",  {31'd0, req_ready},      32'd1);
    check("rst_busy",       {31'd0, busy},           32'd0);
    check("rst_newservice", {31'd0, dat_newService}, 32'd0);
    check("rst_dat_reset",  {31'd0, dat_reset},      32'd0);
    check("rst_blocks",     {16'd0, blocks_done},    32'd0);
    check("rst_timeout",    {16'd0, dat_timeout},    32'd0);
    reset = 1'b1;
    tick();

    // ---- 1: read, 3 blocks, no stalls ----
    ns_before = ns_count;
    start_req(1'b0, 3, 9, 100, 1'b0, 3);
    check("t1_req_ready_low", {31'd0, req_ready},         32'd0);
    check("t1_busy",          {31'd0, busy},              32'd1);
    check("t1_blocksize",     {28'd0, dat_blockSize},     32'd9);
    check("t1_timeout",       {16'd0, dat_timeout},       32'd100);
    check("t1_toen",          {31'd0, dat_timeoutenable}, 32'd1);
    check("t1_dir",           {31'd0, dat_writeRead},     32'd0);
    check("t1_multiblock",    {31'd0, dat_multiblock},    32'd1);
    tick();
    check("t1_first_ns_latency", {31'd0, dat_newService}, 32'd1);
    complete_block();
    check("t1_ns_low_in_next", {31'd0, dat_newService}, 32'd0);
    tick();
    check("t1_ns_low_in_stall", {31'd0, dat_newService}, 32'd0);
    tick();
    check("t1_refire_latency", {31'd0, dat_newService}, 32'd1);
    complete_block();
    wait_ns("t1_b3");
    check("t1_multiblock_last", {31'd0, dat_multiblock}, 32'd0);
    complete_block();
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd1);
    tick();
    check("t1_req_ready_back", {31'd0, req_ready},   32'd1);
    check("t1_done_single",    {31'd0, done},        32'd0);
    check("t1_blocks_hold",    {16'd0, blocks_done}, 32'd3);
    check("t1_ns_count",       ns_count - ns_before, 32'd3);

    // ---- 2: write with fifo_empty held 10 cycles after accept ----
    fifo_empty = 1'b1;
    start_req(1'b1, 1, 2, 5, 1'b0, 1);
    check("t2_dir", {31'd0, dat_writeRead}, 32'd1);
    ns_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (dat_newService === 1'b1) ns_seen++;
      tick();
    end
    check("t2_no_ns_while_empty", ns_seen, 32'd0);
    fifo_empty = 1'b0;
    tick();
    check("t2_ns_after_release", {31'd0, dat_newService}, 32'd1);
    complete_block();
    repeat (2) tick();
    check("t2_idle", {31'd0, req_ready}, 32'd1);

    // ---- 3: req_blocks = 0 treated as one block ----
    ns_before = ns_count;
    start_req(1'b0, 0, 3, 0, 1'b0, 1);
    check("t3_multiblock_stall", {31'd0, dat_multiblock},    32'd0);
    check("t3_toen_off",         {31'd0, dat_timeoutenable}, 32'd0);
    wait_ns("t3");
    tick();
    check("t3_multiblock_wait", {31'd0, dat_multiblock}, 32'd0);
    dat_complete = 1'b1;
    tick();
    dat_complete = 1'b0;
    repeat (2) tick();
    check("t3_ns_count", ns_count - ns_before, 32'd1);
    check("t3_blocks",   {16'd0, blocks_done}, 32'd1);

`ifndef DAT_SEQ_RETRY_EN
    // ---- 4: timeout on block 2 of 4, no retry ----
    start_req(1'b1, 4, 1, 0, 1'b1, 1);
    wait_ns("t4_b1");
    complete_block();
    wait_ns("t4_b2");
    tick();
    dat_timeOutFail = 1'b1;
    tick();
    dat_timeOutFail = 1'b0;
    check("t4_error",     {31'd0, error},     32'd1);
    check("t4_dat_reset", {31'd0, dat_reset}, 32'd1);
    check("t4_no_done",   {31'd0, done},      32'd0);
    tick();
    check("t4_req_ready",   {31'd0, req_ready},   32'd1);
    check("t4_reset_clear", {31'd0, dat_reset},   32'd0);
    check("t4_blocks_hold", {16'd0, blocks_done}, 32'd1);
`else
    // ---- 6: two timeouts then completion, retry enabled ----
    ns_before = ns_count;
    start_req(1'b0, 2, 4, 20, 1'b0, 2);
    for (int r = 0; r < 2; r++) begin
      wait_ns("t6_retry");
      tick();
      dat_timeOutFail = 1'b1;
      tick();
      dat_timeOutFail = 1'b0;
      check("t6_retry_dat_reset", {31'd0, dat_reset}, 32'd1);
      check("t6_retry_no_error",  {31'd0, error},     32'd0);
      check("t6_retry_busy",      {31'd0, busy},      32'd1);
    end
    wait_ns("t6_b1_final");
    complete_block();
    wait_ns("t6_b2");
    complete_block();
    repeat (2) tick();
    check("t6_ns_count", ns_count - ns_before, 32'd4);
    check("t6_blocks",   {16'd0, blocks_done}, 32'd2);
`endif

    // ---- 5: abort and complete in the same WAIT cycle ----
    start_req(1'b0, 2, 5, 7, 1'b1, 0);
    wait_ns("t5");
    tick();
    abort        = 1'b1;
    dat_complete = 1'b1;
    tick();
    abort        = 1'b0;
    dat_complete = 1'b0;
    check("t5_error",  {31'd0, error},       32'd1);
    check("t5_blocks", {16'd0, blocks_done}, 32'd0);
    tick();
    // abort while idle must be ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle_abort_ready", {31'd0, req_ready}, 32'd1);
    check("t5_idle_abort_error", {31'd0, error},     32'd0);

    // ---- reset mid-transfer ----
    req_write      = 1'b0;
    req_blocks     = CNT_W'(5);
    req_block_size = 4'd7;
    req_timeout    = TO_W'(33);
    req_valid      = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_ns("rm");
    tick();
    reset = 1'b0;
    #1;
    check("rm_busy",      {31'd0, busy},           32'd0);
    check("rm_ready",     {31'd0, req_ready},      32'd1);
    check("rm_blocksize", {28'd0, dat_blockSize},  32'd0);
    check("rm_timeout",   {16'd0, dat_timeout},    32'd0);
    check("rm_multi",     {31'd0, dat_multiblock}, 32'd0);
    tick();
    check("rm_no_error", {31'd0, error}, 32'd0);
    check("rm_no_done",  {31'd0, done},  32'd0);
    reset = 1'b1;
    repeat (2) tick();

    check("sb_drained", sb.size(), 32'd0);
    check("end_count",  end_count, pushed);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
